// File: rtl/sha256_miner_pkg.sv
// rtl/sha256_miner_pkg.sv - shared miner widths, nonce-offset helper and golden-nonce record
package sha256_miner_pkg;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
    } golden_nonce_t;

    // Two 64-round transforms at LOOP rounds per cycle plus four register stages around them.
    function automatic logic [NONCE_W-1:0] default_nonce_offset(input int loop);
        return 32'(2 * (64 / loop) + 4);
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// rtl/gn_fifo.sv - show-ahead golden-nonce FIFO with push/pop/full/empty
module gn_fifo
    import sha256_miner_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  golden_nonce_t wr_data,
    output golden_nonce_t rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    golden_nonce_t mem_q [DEPTH];
    golden_nonce_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sha256_golden_nonce_detect.sv
// rtl/sha256_golden_nonce_detect.sv - golden-nonce compare, nonce recovery, blanking and queueing
module sha256_golden_nonce_detect
    import sha256_miner_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_OFFSET = default_nonce_offset(1),
    parameter int                 ZERO_BITS    = 32,
    parameter int                 FIFO_DEPTH   = 4,
    parameter int                 BLANK_CYCLES = 132
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hash_valid,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic [NONCE_W-1:0] nonce_in,
    input  logic               new_work,
    output logic               gn_valid,
    input  logic               gn_ready,
    output logic [NONCE_W-1:0] gn_nonce,
    output logic [15:0]        gn_count,
    output logic               overflow,
    output logic               blanking
);

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

    logic [7:0]         blank_cnt_q, blank_cnt_d;
    logic               cand_v_q, cand_v_d;
    logic [NONCE_W-1:0] cand_nonce_q, cand_nonce_d;
    logic [15:0]        gn_count_q, gn_count_d;
    logic               overflow_q, overflow_d;

    logic               hash_zero, match;
    logic               fifo_full, fifo_empty, fifo_pop, push_ok, drop;
    golden_nonce_t      fifo_wr, fifo_rd;
    logic               unused_hash_bits;

    assign hash_zero        = (hash_in[HASH_W-1 -: ZERO_BITS] == '0);
    assign unused_hash_bits = ^hash_in;
    // new_work itself is blanked: the counter only becomes nonzero on the following cycle.
    assign match            = hash_valid && hash_zero && !blanking && !new_work;

    assign gn_valid = !fifo_empty;
    assign fifo_pop = gn_valid && gn_ready;
    assign push_ok  = cand_v_q && (!fifo_full || fifo_pop);
    assign drop     = cand_v_q && fifo_full && !fifo_pop;
    assign fifo_wr.nonce = cand_nonce_q;

    always_comb begin
        blank_cnt_d = blank_cnt_q;
        if (new_work) begin
            blank_cnt_d = BLANK_LOAD;
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - 8'd1;
        end

        cand_v_d     = match;
        cand_nonce_d = cand_nonce_q;
        if (match) begin
            cand_nonce_d = nonce_in - NONCE_OFFSET;
        end

        gn_count_d = gn_count_q;
        if (push_ok && (gn_count_q != 16'hFFFF)) begin
            gn_count_d = gn_count_q + 16'd1;
        end

        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt_q  <= '0;
            cand_v_q     <= 1'b0;
            cand_nonce_q <= '0;
            gn_count_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            blank_cnt_q  <= blank_cnt_d;
            cand_v_q     <= cand_v_d;
            cand_nonce_q <= cand_nonce_d;
            gn_count_q   <= gn_count_d;
            overflow_q   <= overflow_d;
        end
    end

    gn_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_gn_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_ok),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign gn_nonce = fifo_rd.nonce;
    assign gn_count = gn_count_q;
    assign overflow = overflow_q;
    assign blanking = (blank_cnt_q != '0);

endmodule

// File: tb/tb_sha256_golden_nonce_detect.sv
// tb/tb_sha256_golden_nonce_detect.sv - self-checking bench for sha256_golden_nonce_detect
module tb_sha256_golden_nonce_detect;

    localparam int          BLANK = 132;
    localparam logic [31:0] OFFS  = 32'd132;
    localparam int          DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash_in = '0;
    logic [31:0]  nonce_in = '0;
    logic         new_work = 1'b0;
    logic         gn_ready = 1'b0;
    logic         gn_valid, overflow, blanking;
    logic [31:0]  gn_nonce;
    logic [15:0]  gn_count;

    sha256_golden_nonce_detect #(
        .NONCE_OFFSET (OFFS),
        .ZERO_BITS    (32),
        .FIFO_DEPTH   (DEPTH),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hash_valid (hash_valid),
        .hash_in    (hash_in),
        .nonce_in   (nonce_in),
        .new_work   (new_work),
        .gn_valid   (gn_valid),
        .gn_ready   (gn_ready),
        .gn_nonce   (gn_nonce),
        .gn_count   (gn_count),
        .overflow   (overflow),
        .blanking   (blanking)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Reference model: queue of found nonces, one pending candidate, cycle of last new_work.
    logic [31:0] mq[$];
    bit          m_cand;
    logic [31:0] m_cand_nonce;
    int          m_count;
    bit          m_ovf;
    int          cyc;
    int          last_nw;
    bit          prev_m_valid;
    logic [31:0] prev_nonce;

    function automatic bit m_blank(input int c);
        return ((c - last_nw) >= 1) && ((c - last_nw) <= BLANK);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cand       = 0;
        m_cand_nonce = '0;
        m_count      = 0;
        m_ovf        = 0;
        cyc          = 0;
        last_nw      = -100000;
        prev_m_valid = 0;
        prev_nonce   = '0;
    endtask

    task automatic cycle(input bit hv, input logic [31:0] top, input logic [31:0] nonce,
                         input bit nw, input bit rdy);
        bit match;
        bit pop;
        hash_valid = hv;
        hash_in    = {top, $urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom()};
        nonce_in   = nonce;
        new_work   = nw;
        gn_ready   = rdy;

        match = hv && (top == 32'd0) && !m_blank(cyc) && !nw;
        pop   = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (m_cand) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(m_cand_nonce);
                if (m_count < 65535) m_count++;
            end else begin
                m_ovf = 1;
            end
        end
        m_cand       = match;
        m_cand_nonce = nonce - OFFS;
        if (nw) last_nw = cyc;
        cyc++;

        @(posedge clk);
        #1;
        check("gn_valid", gn_valid, mq.size() > 0);
        if (mq.size() > 0) check("gn_nonce", gn_nonce, mq[0]);
        else if (!prev_m_valid) check("gn_nonce_stable", gn_nonce, prev_nonce);
        check("gn_count", gn_count, m_count);
        check("overflow", overflow, m_ovf);
        check("blanking", blanking, m_blank(cyc));
        prev_m_valid = (mq.size() > 0);
        prev_nonce   = gn_nonce;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        hash_valid = 1'b0;
        new_work   = 1'b0;
        gn_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          hv;
        logic [31:0] top;
        logic [31:0] nonce;
        bit          rdy;
        bit          ev;
        logic [31:0] en;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bl;
        int seen;
        logic [31:0] first;
        logic [31:0] rn;

        vecs[0] = '{1, 32'h0000_0001, 32'h0000_2000, 0, 0, 32'h0, 16'd0};
        vecs[1] = '{0, 32'h0,         32'h0,         0, 0, 32'h0, 16'd0};
        vecs[2] = '{1, 32'h0,         32'h0000_1000, 0, 0, 32'h0, 16'd0};
        vecs[3] = '{0, 32'h0,         32'h0,         0, 1, 32'h0000_0F7C, 16'd1};
        vecs[4] = '{0, 32'h0,         32'h0,         1, 0, 32'h0, 16'd1};
        vecs[5] = '{1, 32'h0,         32'd5,         0, 0, 32'h0, 16'd1};
        vecs[6] = '{0, 32'h0,         32'h0,         0, 1, 32'hFFFF_FF81, 16'd2};
        vecs[7] = '{1, 32'h8000_0000, 32'd7,         1, 0, 32'h0, 16'd2};

        do_reset();
        check("rst_gn_valid", gn_valid, 0);
        check("rst_gn_nonce", gn_nonce, 0);
        check("rst_gn_count", gn_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_blanking", blanking, 0);

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].hv, vecs[i].top, vecs[i].nonce, 0, vecs[i].rdy);
            check("vec_valid", gn_valid, vecs[i].ev);
            if (vecs[i].ev) check("vec_nonce", gn_nonce, vecs[i].en);
            check("vec_count", gn_count, vecs[i].ec);
        end

        // Overflow: five matches with the consumer stalled.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h0, 32'd200 + i, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_count", gn_count, 4);
        for (int k = 0; k < 4; k++) begin
            check("ovf_pop_valid", gn_valid, 1);
            check("ovf_pop_order", gn_nonce, 32'd68 + k);
            cycle(0, 32'h0, 32'h0, 0, 1);
        end
        check("ovf_drained", gn_valid, 0);

        // Full boundary: push and pop in the same cycle while full.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 32'h0, 32'd300 + i, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 1);
        check("full_no_ovf", overflow, 0);
        check("full_count", gn_count, 5);
        for (int k = 0; k < 4; k++) begin
            check("full_order", gn_nonce, 32'd169 + k);
            cycle(0, 32'h0, 32'h0, 0, 1);
        end
        check("full_drained", gn_valid, 0);

        // Blanking after a single new_work.
        do_reset();
        bl = 0; seen = 0; first = '0;
        for (int k = 0; k <= 140; k++) begin
            cycle(1, 32'h0, 32'd1000 + k, k == 0, 1);
            if (blanking) bl++;
            if (gn_valid && !seen) begin seen = 1; first = gn_nonce; end
        end
        check("blank_len", bl, 132);
        check("blank_first_seen", seen, 1);
        check("blank_first", first, 32'd1001);

        // Blanking extended by a second new_work.
        do_reset();
        bl = 0; seen = 0; first = '0;
        for (int k = 0; k <= 190; k++) begin
            cycle(1, 32'h0, 32'd1000 + k, (k == 0) || (k == 50), 1);
            if (blanking) bl++;
            if (gn_valid && !seen) begin seen = 1; first = gn_nonce; end
        end
        check("reblank_len", bl, 182);
        check("reblank_first", first, 32'd1051);

        // Asynchronous reset with three entries queued and a candidate pending.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h0, 32'd400 + i, 0, 0);
        check("pre_rst_count", gn_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", gn_valid, 0);
        check("arst_count", gn_count, 0);
        check("arst_overflow", overflow, 0);
        hash_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 32'h0, 32'h0, 0, 1);
            if (gn_valid) seen++;
        end
        check("no_stale_entry", seen, 0);

        // Randomized traffic against the reference model.
        do_reset();
        rn = $urandom();
        for (int k = 0; k < 4000; k++) begin
            logic [31:0] top;
            bit rdy;
            case ($urandom_range(0, 3))
                0:       top = 32'h0;
                1:       top = 32'h1 << $urandom_range(0, 31);
                default: top = $urandom();
            endcase
            rdy = (k < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 1) == 1, top, rn, $urandom_range(0, 299) == 0, rdy);
            rn = rn + 32'd1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha256_golden_nonce_detect.md
Name: sha256_golden_nonce_detect

Overview:
- Sits directly downstream of the second (double-hash) SHA-256 transform stage in the miner.
- Each cycle with a valid hash, checks whether the top ZERO_BITS bits of the 256-bit hash are zero. On a match, recovers the nonce that produced the hash by subtracting the fixed pipeline depth from the live nonce counter.
- Queues found ("golden") nonces in a small FIFO drained through a valid/ready handshake towards the host interface.
- Blanks detection for a programmable window after new work is loaded, so stale in-flight hashes are not reported.

Parameters:
- NONCE_OFFSET, 32'd132: nonce counter advance between issuing a nonce and its final hash appearing at hash_in.
- ZERO_BITS, 32: number of MSBs of hash_in that must be zero for a match. Legal range 1..64.
- FIFO_DEPTH, 4: golden-nonce queue entries. Power of two, at least 2.
- BLANK_CYCLES, 132: cycles of suppressed detection after new_work. Range 0..255.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- hash_valid, in, 1: hash_in carries a completed hash this cycle.
- hash_in, in, 256: final hash. Bits 255:224 are state word 7 (the most significant word).
- nonce_in, in, 32: value of the nonce counter in the same cycle.
- new_work, in, 1: single-cycle pulse marking that a new work unit has been loaded.
- gn_valid, out, 1: FIFO head holds a golden nonce.
- gn_ready, in, 1: consumer accepts the head this cycle.
- gn_nonce, out, 32: FIFO head value. Meaningful only when gn_valid=1.
- gn_count, out, 16: accepted golden nonces since reset. Saturates at 16'hFFFF.
- overflow, out, 1: sticky flag; a golden nonce was dropped because the FIFO was full.
- blanking, out, 1: detection is currently suppressed.

Behaviour:
- Reset (asynchronous, rst_n=0): gn_valid=0, gn_nonce=0, gn_count=0, overflow=0, blanking=0. FIFO is emptied, blank counter=0, stage-1 register is cleared (cand_v=0).
- Match condition: hash_valid && (hash_in[255 -: ZERO_BITS] == 0) && !blanking && !new_work.
- Stage 1 (registered): on cycle N, cand_v <= match, and cand_nonce <= nonce_in - NONCE_OFFSET.
  - The subtraction is modulo 2^32 and wraps. Example: nonce_in=5, offset 132 gives 32'hFFFFFF81.
- Stage 2: in cycle N+1, if cand_v=1, push cand_nonce into the FIFO. gn_valid rises at cycle N+2 when the FIFO was empty.
- Latency from hash_valid to gn_valid is therefore 2 cycles.
- FIFO (show-ahead):
  - gn_nonce always presents the head entry.
  - A pop occurs when gn_valid && gn_ready.
  - With a push and no pop, count increments. With a pop and no push, count decrements.
  - Simultaneous push and pop keeps count unchanged. This holds when full: the pop frees the slot and the push is accepted.
  - Simultaneous push and pop while empty: no pop happens (gn_valid=0), and the push is accepted.
  - A push while full with no pop drops the entry, sets overflow=1 and does not increment gn_count.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- gn_count: +1 on each accepted push. Holds at 16'hFFFF once reached.
- overflow: cleared only by reset.
- Blanking counter:
  - new_work loads BLANK_CYCLES. Otherwise the counter decrements by 1 per cycle while nonzero.
  - blanking = (counter != 0).
  - new_work while the counter is already running reloads it to BLANK_CYCLES.
  - With BLANK_CYCLES=0, only the new_work cycle itself is suppressed.
- new_work affects neither the FIFO contents nor an already-registered cand_v. Candidates captured before the pulse are still pushed.
- gn_nonce is undefined-but-stable while gn_valid=0. It must not toggle on its own.
- No combinational path from gn_ready to gn_valid.

Decomposition:
- Shared package sha256_miner_pkg holds:
  - NONCE_W=32 and HASH_W=256.
  - the default NONCE_OFFSET per unroll factor, as a function of LOOP.
  - the golden-nonce record type (a 32-bit nonce).
- One sub-module, gn_fifo: a parameterised synchronous show-ahead FIFO with push, pop, full, empty and asynchronous active-low reset. The detector instantiates it once.
- Compare, nonce recovery, blanking and counters live in the top module.

Test Plan:
- Match timing: after reset, drive hash_valid=1, hash_in[255:224]=0, nonce_in=32'h0000_1000 at cycle N. Required: gn_valid=1 at N+2, gn_nonce=32'h0000_0F7C, gn_count=1.
- Near-miss: hash_in[255:224]=32'h0000_0001 with hash_valid=1. Required: gn_valid stays 0, gn_count=0.
- Nonce wrap: match with nonce_in=32'd5. Required: gn_nonce=32'hFFFFFF81.
- Overflow: hold gn_ready=0 and inject 5 matches with nonce_in=200..204. Required:
  - FIFO holds 68..71 in order;
  - overflow=1 after the 5th push;
  - gn_count=4;
  - popping yields 68, 69, 70, 71, then gn_valid=0.
- Full boundary: with the FIFO full, assert gn_ready=1 in the same cycle as a push. Required: no drop, overflow stays 0, count stays 4.
- Blanking: pulse new_work at cycle T, then inject matches every cycle.
  - Required: blanking=1 for T+1..T+132, and no pushes from matches in cycles T..T+132.
  - The first reported nonce is from the match at T+133.
  - A second new_work at T+50 extends blanking to T+182.
- Reset mid-operation: assert rst_n=0 with 3 entries queued and cand_v=1. Required:
  - gn_valid=0, gn_count=0, overflow=0 immediately (asynchronous);
  - after release, no stale entry ever appears.
